// File: rtl/c_gate_bank_v5_0.sv
// Multi-channel run-time selectable gate reduction (AND/NAND/OR/NOR/XOR/XNOR)
// with per-input inversion, a valid-tagged pipeline, clock-enable stall and synchronous init.
module c_gate_bank_v5_0 #(
    parameter int unsigned             C_CHANNELS       = 4,
    parameter int unsigned             C_INPUTS         = 2,
    parameter logic [C_INPUTS-1:0]     C_INPUT_INV_MASK = '0,
    parameter int unsigned             C_PIPE_STAGES    = 0,
    parameter logic [C_CHANNELS-1:0]   C_SINIT_VAL      = '0,
    parameter bit                      C_HAS_CE         = 1'b0
) (
    input  logic                             CLK,
    input  logic                             ACLR_N,
    input  logic                             CE,
    input  logic                             SINIT,
    input  logic [C_CHANNELS*C_INPUTS-1:0]   I,
    input  logic [2:0]                       MODE,
    input  logic                             IVALID,
    output logic [C_CHANNELS-1:0]            O,
    output logic [C_CHANNELS-1:0]            Q,
    output logic                             OVALID,
    output logic                             ERR
);

    localparam int unsigned NSTG = C_PIPE_STAGES + 1;

    localparam logic [2:0] MODE_AND  = 3'd0;
    localparam logic [2:0] MODE_NAND = 3'd1;
    localparam logic [2:0] MODE_OR   = 3'd2;
    localparam logic [2:0] MODE_NOR  = 3'd3;
    localparam logic [2:0] MODE_XOR  = 3'd4;
    localparam logic [2:0] MODE_XNOR = 3'd5;

    logic [C_CHANNELS-1:0]            gate;
    logic [C_INPUTS-1:0]              chan_x;
    logic                             mode_bad;
    logic                             ce_eff;
    logic [NSTG-1:0][C_CHANNELS-1:0]  data_q;
    logic [NSTG-1:0]                  valid_q;
    logic [NSTG:0][C_CHANNELS-1:0]    data_shift;
    logic [NSTG:0]                    valid_shift;
    logic                             err_q;

    assign mode_bad = (MODE > MODE_XNOR);
    assign ce_eff   = C_HAS_CE ? CE : 1'b1;

    // Per-channel reduction of the masked inputs; illegal modes force zero
    always_comb begin
        gate   = '0;
        chan_x = '0;
        for (int k = 0; k < int'(C_CHANNELS); k++) begin
            chan_x = I[k*C_INPUTS +: C_INPUTS] ^ C_INPUT_INV_MASK;
            case (MODE)
                MODE_AND:  gate[k] = &chan_x;
                MODE_NAND: gate[k] = ~&chan_x;
                MODE_OR:   gate[k] = |chan_x;
                MODE_NOR:  gate[k] = ~|chan_x;
                MODE_XOR:  gate[k] = ^chan_x;
                MODE_XNOR: gate[k] = ~^chan_x;
                default:   gate[k] = 1'b0;
            endcase
        end
    end

    assign O = gate;

    // One-slot shift built by concatenation so a single-stage pipeline needs no special case
    assign data_shift  = {data_q, gate};
    assign valid_shift = {valid_q, IVALID};

    // Pipeline registers; SINIT outranks CE, bubbles still load data
    always_ff @(posedge CLK or negedge ACLR_N) begin
        if (!ACLR_N) begin
            data_q  <= '0;
            valid_q <= '0;
            err_q   <= 1'b0;
        end else if (SINIT) begin
            data_q         <= '0;
            data_q[NSTG-1] <= C_SINIT_VAL;
            valid_q        <= '0;
            err_q          <= 1'b0;
        end else if (ce_eff) begin
            data_q  <= data_shift[NSTG-1:0];
            valid_q <= valid_shift[NSTG-1:0];
            if (IVALID && mode_bad) begin
                err_q <= 1'b1;
            end
        end
    end

    assign Q      = data_q[NSTG-1];
    assign OVALID = valid_q[NSTG-1];
    assign ERR    = err_q;

endmodule

// File: tb/tb_c_gate_bank_v5_0.sv
// Directed bench for c_gate_bank_v5_0: a 2x3 unpipelined bank and a masked 4x3 bank
// with three extra stages, sharing control inputs.
module tb_c_gate_bank_v5_0;

    logic        clk;
    logic        rst_n;
    logic        ce;
    logic        sinit;
    logic [2:0]  mode;
    logic        ivalid;
    logic [5:0]  a_i;
    logic [11:0] b_i;
    logic [1:0]  a_o, a_q;
    logic        a_ov, a_err;
    logic [3:0]  b_o, b_q;
    logic        b_ov, b_err;

    int n_cmp = 0;
    int n_bad = 0;

    // Channel patterns for the masked AND bank: 3'b110 ^ 3'b001 = 111 -> 1, 3'b000 -> 0
    localparam logic [11:0] P0  = 12'b000_110_000_110;  // O = 0101
    localparam logic [11:0] P1  = 12'b110_000_110_000;  // O = 1010
    localparam logic [11:0] P2  = 12'b110_110_110_110;  // O = 1111
    localparam logic [11:0] BUB = 12'b000_000_000_110;  // O = 0001

    c_gate_bank_v5_0 #(
        .C_CHANNELS(2), .C_INPUTS(3), .C_INPUT_INV_MASK(3'b000),
        .C_PIPE_STAGES(0), .C_SINIT_VAL(2'b00), .C_HAS_CE(1'b1)
    ) u_a (
        .CLK(clk), .ACLR_N(rst_n), .CE(ce), .SINIT(sinit), .I(a_i), .MODE(mode),
        .IVALID(ivalid), .O(a_o), .Q(a_q), .OVALID(a_ov), .ERR(a_err)
    );

    c_gate_bank_v5_0 #(
        .C_CHANNELS(4), .C_INPUTS(3), .C_INPUT_INV_MASK(3'b001),
        .C_PIPE_STAGES(3), .C_SINIT_VAL(4'b1010), .C_HAS_CE(1'b1)
    ) u_b (
        .CLK(clk), .ACLR_N(rst_n), .CE(ce), .SINIT(sinit), .I(b_i), .MODE(mode),
        .IVALID(ivalid), .O(b_o), .Q(b_q), .OVALID(b_ov), .ERR(b_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic b_edge(input string tag, input logic ce_v, input logic iv_v,
                          input logic [11:0] i_v, input logic exp_ov, input logic [3:0] exp_q);
        ce     = ce_v;
        ivalid = iv_v;
        b_i    = i_v;
        step();
        chk({tag, "_ov"}, 32'(b_ov), 32'(exp_ov));
        chk({tag, "_q"},  32'(b_q),  32'(exp_q));
    endtask

    function automatic logic [31:0] ref_gate(input logic [31:0] iv, input int nch, input int nin,
                                             input logic [15:0] mask, input logic [2:0] md);
        logic [31:0] r;
        logic        a, o, x, b;
        r = '0;
        for (int k = 0; k < nch; k++) begin
            a = 1'b1; o = 1'b0; x = 1'b0;
            for (int j = 0; j < nin; j++) begin
                b = iv[k*nin+j] ^ mask[j];
                a = a & b;
                o = o | b;
                x = x ^ b;
            end
            case (md)
                3'd0:    r[k] = a;
                3'd1:    r[k] = ~a;
                3'd2:    r[k] = o;
                3'd3:    r[k] = ~o;
                3'd4:    r[k] = x;
                3'd5:    r[k] = ~x;
                default: r[k] = 1'b0;
            endcase
        end
        return r;
    endfunction

    initial begin
        rst_n = 1'b0; ce = 1'b1; sinit = 1'b0; mode = 3'd0; ivalid = 1'b0;
        a_i = 6'b111_011; b_i = '0;
        #7;
        chk("rst_a_q",   32'(a_q),   32'd0);
        chk("rst_a_ov",  32'(a_ov),  32'd0);
        chk("rst_a_err", 32'(a_err), 32'd0);
        chk("rst_b_q",   32'(b_q),   32'd0);
        chk("rst_b_ov",  32'(b_ov),  32'd0);
        chk("rst_a_o",   32'(a_o),   32'b10);
        #1 rst_n = 1'b1;

        // AND then XOR on 111_011
        ivalid = 1'b1;
        #1 chk("and_o", 32'(a_o), 32'b10);
        step();
        chk("and_q",  32'(a_q),  32'b10);
        chk("and_ov", 32'(a_ov), 32'd1);
        mode = 3'd4;
        #1 chk("xor_o", 32'(a_o), 32'b10);
        ivalid = 1'b0;

        // Illegal mode with valid: zero result still propagates, ERR sticks
        mode = 3'd6; ivalid = 1'b1; a_i = 6'b111_111;
        #1 chk("ill_o", 32'(a_o), 32'd0);
        chk("ill_err_pre", 32'(a_err), 32'd0);
        step();
        chk("ill_err", 32'(a_err), 32'd1);
        chk("ill_q",   32'(a_q),   32'd0);
        chk("ill_ov",  32'(a_ov),  32'd1);
        chk("ill_b_err", 32'(b_err), 32'd1);
        ivalid = 1'b0;
        step();
        chk("ill_err_hold", 32'(a_err), 32'd1);
        chk("ill_ov_drop",  32'(a_ov),  32'd0);
        mode = 3'd0; ivalid = 1'b1; a_i = 6'b111_011;
        step();
        chk("ill_err_legal", 32'(a_err), 32'd1);
        chk("ill_q_legal",   32'(a_q),   32'b10);
        ivalid = 1'b0;

        // Masked NOR: channel0 001 ^ 001 = 000 -> 1, others 000 ^ 001 -> 0
        mode = 3'd3; b_i = 12'b000_000_000_001;
        #1 chk("mask_nor_o", 32'(b_o), 32'b0001);

        for (int n = 0; n < 1000; n++) begin
            mode = 3'($urandom_range(0, 7));
            a_i  = 6'($urandom);
            b_i  = 12'($urandom);
            #1;
            chk("rnd_a_o", 32'(a_o), ref_gate(32'(a_i), 2, 3, 16'h0000, mode));
            chk("rnd_b_o", 32'(b_o), ref_gate(32'(b_i), 4, 3, 16'h0001, mode));
        end

        // Clean start for the pipeline tests
        mode = 3'd0; ivalid = 1'b0; sinit = 1'b1;
        step();
        sinit = 1'b0;
        chk("si0_q",   32'(b_q),   32'b1010);
        chk("si0_ov",  32'(b_ov),  32'd0);
        chk("si0_err", 32'(b_err), 32'd0);
        chk("si0_a_err", 32'(a_err), 32'd0);

        // Pulses on cycles 0, 2, 3 -> OVALID on edges 4, 6, 7
        b_edge("p1", 1, 1, P0,  0, 4'b0000);
        b_edge("p2", 1, 0, BUB, 0, 4'b0000);
        b_edge("p3", 1, 1, P1,  0, 4'b0000);
        b_edge("p4", 1, 1, P2,  1, 4'b0101);
        b_edge("p5", 1, 0, BUB, 0, 4'b0001);
        b_edge("p6", 1, 0, BUB, 1, 4'b1010);
        b_edge("p7", 1, 0, BUB, 1, 4'b1111);
        b_edge("p8", 1, 0, BUB, 0, 4'b0001);

        // Two-cycle CE stall mid-flight delays each pulse by two edges
        b_edge("s1",  1, 1, P0,  0, 4'b0001);
        b_edge("s2",  1, 0, BUB, 0, 4'b0001);
        b_edge("s3",  1, 1, P1,  0, 4'b0001);
        b_edge("s4",  0, 0, BUB, 0, 4'b0001);
        b_edge("s5",  0, 0, BUB, 0, 4'b0001);
        b_edge("s6",  1, 1, P2,  1, 4'b0101);
        b_edge("s7",  1, 0, BUB, 0, 4'b0001);
        b_edge("s8",  1, 0, BUB, 1, 4'b1010);
        b_edge("s9",  1, 0, BUB, 1, 4'b1111);
        b_edge("s10", 1, 0, BUB, 0, 4'b0001);

        // Full pipeline incl. an illegal transaction, then SINIT with CE low
        ce = 1'b1; ivalid = 1'b1; mode = 3'd7; b_i = P0;
        step();
        mode = 3'd0; b_i = P0; step();
        b_i = P1; step();
        b_i = P2; step();
        chk("full_ov",  32'(b_ov),  32'd1);
        chk("full_q",   32'(b_q),   32'd0);
        chk("full_err", 32'(b_err), 32'd1);
        ce = 1'b0; sinit = 1'b1; ivalid = 1'b0;
        step();
        sinit = 1'b0;
        chk("sinit_q",   32'(b_q),   32'b1010);
        chk("sinit_ov",  32'(b_ov),  32'd0);
        chk("sinit_err", 32'(b_err), 32'd0);
        for (int n = 0; n < 4; n++) b_edge("post_si", 1, 0, 12'h000, 0, 4'b0000);

        // Illegal mode without valid leaves ERR clear
        mode = 3'd7;
        b_edge("ill_nv", 1, 0, 12'h000, 0, 4'b0000);
        chk("ill_nv_a_err", 32'(a_err), 32'd0);
        chk("ill_nv_b_err", 32'(b_err), 32'd0);
        mode = 3'd0;

        // Async reset between edges with three transactions in flight
        ivalid = 1'b1;
        b_i = P2; step();
        b_i = P0; step();
        b_i = P1; step();
        b_i = P2; step();
        chk("pre_rst_q",  32'(b_q),  32'b1111);
        chk("pre_rst_ov", 32'(b_ov), 32'd1);
        ivalid = 1'b0; b_i = 12'h000;
        #3 rst_n = 1'b0;
        #1;
        chk("rst_mid_q",   32'(b_q),  32'd0);
        chk("rst_mid_ov",  32'(b_ov), 32'd0);
        chk("rst_mid_a_q", 32'(a_q),  32'd0);
        #2 rst_n = 1'b1;
        for (int n = 0; n < 4; n++) b_edge("post_rst", 1, 0, 12'h000, 0, 4'b0000);
        b_edge("new1", 1, 1, P1,      0, 4'b0000);
        b_edge("new2", 1, 0, 12'h000, 0, 4'b0000);
        b_edge("new3", 1, 0, 12'h000, 0, 4'b0000);
        b_edge("new4", 1, 0, 12'h000, 1, 4'b1010);
        b_edge("new5", 1, 0, 12'h000, 0, 4'b0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
